cmd_seq_multi: RTL

Parametrised multi-channel command sequencer for the FE command path. It replays a bit pattern stored in a byte-wide RAM, MSB first, onto up to CHANNELS FE command lines. It supports repeat counts, start/stop trimming of repeated passes, a per-channel output mask and an optional external start. It sits on the BUS register interface, replaces the single-channel sequencer, and drives the CMD_DATA lines of the FE models and chips.

---
 rtl/cmd_seq_multi.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_seq_multi.sv
// Multi-channel command sequencer: replays a byte-wide pattern RAM MSB first onto CHANNELS command lines.
// Optional external start is built when CMD_SEQ_EXT_START_EN is defined.
`timescale 1ns/1ps
module cmd_seq_multi #(
  parameter int ABUSWIDTH = 16,
  parameter int MEM_BYTES = 2048,
  parameter int CHANNELS  = 4
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic [CHANNELS-1:0]  CMD_DATA,
  output logic                 CMD_START_FLAG,
  output logic                 READY
`ifdef CMD_SEQ_EXT_START_EN
  ,
  input  logic                 EXT_START
`endif
);

  localparam int AW       = $clog2(MEM_BYTES);
  localparam int PW       = AW + 3;
  localparam int MAX_BITS = MEM_BYTES * 8;
  localparam int RAM_BASE = 16;

  typedef enum logic [1:0] {IDLE, PREFETCH, SEND, DONE} state_t;

  state_t              state;
  logic                idle_lvl;
  logic                ext_en;
  logic                ext_start_req;
  logic [CHANNELS-1:0] mask_r;
  logic [15:0]         size_r, start_rep_r, stop_rep_r;
  logic [31:0]         repeat_r;

  logic [7:0]    mem [MEM_BYTES];
  logic [7:0]    seq_q;
  logic [AW-1:0] seq_rd_addr;

  logic          soft_rst, start_wr, ram_hit;
  logic [AW-1:0] ram_idx;
  logic [7:0]    reg_rd;

  assign soft_rst = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
  assign start_wr = BUS_WR && (BUS_ADD == ABUSWIDTH'(1));
  assign ram_hit  = (BUS_ADD >= ABUSWIDTH'(RAM_BASE)) && (BUS_ADD < ABUSWIDTH'(RAM_BASE + MEM_BYTES));
  assign ram_idx  = AW'(BUS_ADD - ABUSWIDTH'(RAM_BASE));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N || soft_rst) begin
      idle_lvl    <= 1'b0;
      mask_r      <= '1;
      size_r      <= '0;
      repeat_r    <= 32'd1;
      start_rep_r <= '0;
      stop_rep_r  <= '0;
    end else if (BUS_WR) begin
      case (BUS_ADD)
        ABUSWIDTH'(2):  idle_lvl          <= BUS_DATA_IN[1];
        ABUSWIDTH'(3):  mask_r            <= BUS_DATA_IN[CHANNELS-1:0];
        ABUSWIDTH'(4):  size_r[7:0]       <= BUS_DATA_IN;
        ABUSWIDTH'(5):  size_r[15:8]      <= BUS_DATA_IN;
        ABUSWIDTH'(6):  repeat_r[7:0]     <= BUS_DATA_IN;
        ABUSWIDTH'(7):  repeat_r[15:8]    <= BUS_DATA_IN;
        ABUSWIDTH'(8):  repeat_r[23:16]   <= BUS_DATA_IN;
        ABUSWIDTH'(9):  repeat_r[31:24]   <= BUS_DATA_IN;
        ABUSWIDTH'(10): start_rep_r[7:0]  <= BUS_DATA_IN;
        ABUSWIDTH'(11): start_rep_r[15:8] <= BUS_DATA_IN;
        ABUSWIDTH'(12): stop_rep_r[7:0]   <= BUS_DATA_IN;
        ABUSWIDTH'(13): stop_rep_r[15:8]  <= BUS_DATA_IN;
        default: ;
      endcase
    end
  end

`ifdef CMD_SEQ_EXT_START_EN
  logic [2:0] ext_sync;
  logic       ext_pulse;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      ext_en    <= 1'b0;
      ext_sync  <= '0;
      ext_pulse <= 1'b0;
    end else begin
      if (soft_rst)
        ext_en <= 1'b0;
      else if (BUS_WR && BUS_ADD == ABUSWIDTH'(2))
        ext_en <= BUS_DATA_IN[0];
      // Two synchroniser stages, then a delayed copy for rising-edge detection.
      ext_sync  <= {ext_sync[1:0], EXT_START};
      ext_pulse <= ext_sync[1] & ~ext_sync[2];
    end
  end

  assign ext_start_req = ext_en & ext_pulse;
`else
  assign ext_en        = 1'b0;
  assign ext_start_req = 1'b0;
`endif

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    reg_rd = '0;
    case (BUS_ADD)
      ABUSWIDTH'(1):  reg_rd = {7'b0, READY};
      ABUSWIDTH'(2):  reg_rd = {6'b0, idle_lvl, ext_en};
      ABUSWIDTH'(3):  reg_rd[CHANNELS-1:0] = mask_r;
      ABUSWIDTH'(4):  reg_rd = size_r[7:0];
      ABUSWIDTH'(5):  reg_rd = size_r[15:8];
      ABUSWIDTH'(6):  reg_rd = repeat_r[7:0];
      ABUSWIDTH'(7):  reg_rd = repeat_r[15:8];
      ABUSWIDTH'(8):  reg_rd = repeat_r[23:16];
      ABUSWIDTH'(9):  reg_rd = repeat_r[31:24];
      ABUSWIDTH'(10): reg_rd = start_rep_r[7:0];
      ABUSWIDTH'(11): reg_rd = start_rep_r[15:8];
      ABUSWIDTH'(12): reg_rd = stop_rep_r[7:0];
      ABUSWIDTH'(13): reg_rd = stop_rep_r[15:8];
      default: ;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)
      BUS_DATA_OUT <= '0;
    else if (BUS_RD)
      BUS_DATA_OUT <= ram_hit ? mem[ram_idx] : reg_rd;
  end

  // NOTE: the pattern RAM has no reset; its contents survive soft reset and map onto block RAM.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_WR && ram_hit)
      mem[ram_idx] <= BUS_DATA_IN;
    seq_q <= mem[seq_rd_addr];
  end

  // Pass geometry, evaluated once at start from the live registers.
  logic [17:0] size_eff, trim_len;
  logic        full_range;

  assign size_eff   = ({2'b0, size_r} > 18'(MAX_BITS)) ? 18'(MAX_BITS) : {2'b0, size_r};
  assign trim_len   = size_eff - {2'b0, stop_rep_r};
  assign full_range = ({2'b0, stop_rep_r} >= size_eff) || ({2'b0, start_rep_r} >= trim_len);

  logic [PW-1:0] cur_ptr, end_last, end_mid, pass_begin, pass_end, next_ptr;
  logic [31:0]   rep_cnt;
  logic          rep_inf, is_last, at_end, seq_bit;
  logic [CHANNELS-1:0] send_vec, idle_vec;

  assign is_last     = !rep_inf && (rep_cnt == 32'd1);
  assign pass_end    = is_last ? end_last : end_mid;
  assign at_end      = (cur_ptr == pass_end);
  assign next_ptr    = at_end ? pass_begin : cur_ptr + PW'(1);
  // The byte for the bit emitted next cycle is fetched while the current bit goes out.
  assign seq_rd_addr = (state == PREFETCH || state == SEND) ? next_ptr[PW-1:3] : '0;
  assign seq_bit     = seq_q[~cur_ptr[2:0]];
  assign idle_vec    = {CHANNELS{idle_lvl}};

  always_comb begin
    send_vec = idle_vec;
    for (int c = 0; c < CHANNELS; c++)
      if (mask_r[c]) send_vec[c] = seq_bit;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N || soft_rst) begin
      state          <= IDLE;
      CMD_DATA       <= '0;
      CMD_START_FLAG <= 1'b0;
      READY          <= 1'b1;
      cur_ptr        <= '0;
      end_last       <= '0;
      end_mid        <= '0;
      pass_begin     <= '0;
      rep_cnt        <= '0;
      rep_inf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CMD_DATA       <= idle_vec;
          CMD_START_FLAG <= 1'b0;
          if ((start_wr || ext_start_req) && size_r != 16'd0) begin
            state      <= PREFETCH;
            READY      <= 1'b0;
            cur_ptr    <= '0;
            end_last   <= PW'(size_eff - 18'd1);
            end_mid    <= full_range ? PW'(size_eff - 18'd1) : PW'(trim_len - 18'd1);
            pass_begin <= full_range ? '0 : PW'(start_rep_r);
            rep_cnt    <= repeat_r;
            rep_inf    <= (repeat_r == 32'd0);
          end
        end
        PREFETCH, SEND: begin
          CMD_DATA       <= send_vec;
          CMD_START_FLAG <= (state == PREFETCH);
          cur_ptr        <= next_ptr;
          state          <= SEND;
          if (at_end) begin
            if (is_last)
              state <= DONE;
            else if (!rep_inf)
              rep_cnt <= rep_cnt - 32'd1;
          end
        end
        DONE: begin
          CMD_DATA       <= idle_vec;
          CMD_START_FLAG <= 1'b0;
          READY          <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
